// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter controller: owns the fetch PC, picks the next PC from
// sequential/branch/jump/jr/exception sources and hands one instruction at a time to decode.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exception,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] epc,
  output logic        addr_err
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state_r;
  logic [31:0] fetch_pc_r;
  logic [31:0] instr_r;
  logic        instr_valid_r;
  logic [31:0] pc_r;
  logic [31:0] pc_plus4_r;
  logic [31:0] epc_r;
  logic        addr_err_r;

  logic        redirect_s;
  logic        exc_take_s;
  logic        addr_fault_s;
  logic [31:0] target_s;
  logic        imem_req_s;
  logic        accept_s;

  // Redirect target selection, highest priority first; a misaligned jr behaves as an exception.
  always_comb begin
    exc_take_s   = 1'b0;
    addr_fault_s = 1'b0;
    target_s     = fetch_pc_r;
    if (exception) begin
      exc_take_s = 1'b1;
      target_s   = EXC_VECTOR;
    end else if (jr) begin
      if (jr_target[1:0] != 2'b00) begin
        exc_take_s   = 1'b1;
        addr_fault_s = 1'b1;
        target_s     = EXC_VECTOR;
      end else begin
        target_s = jr_target;
      end
    end else if (jump) begin
      target_s = {pc_plus4_r[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      target_s = branch_target & 32'hFFFF_FFFC;
    end else begin
      target_s = fetch_pc_r;
    end
  end

  // Request qualification: a redirect or a stalled, still-valid instruction blocks the fetch.
  always_comb begin
    redirect_s = ((state_r == FETCH) || (state_r == HOLD)) &&
                 (exception || jr || jump || branch_taken);
    imem_req_s = (state_r == FETCH) && !redirect_s && !(instr_valid_r && stall);
    accept_s   = imem_req_s && imem_ready;
  end

  // Sequencer state, fetch PC and decode-facing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= BOOT;
      fetch_pc_r    <= RESET_PC;
      instr_r       <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      pc_r          <= RESET_PC;
      pc_plus4_r    <= RESET_PC + 32'd4;
      epc_r         <= 32'h0000_0000;
      addr_err_r    <= 1'b0;
    end else begin
      addr_err_r <= 1'b0;
      if (redirect_s) begin
        // Whatever imem returns this cycle belongs to the abandoned path and is dropped.
        fetch_pc_r    <= target_s;
        instr_valid_r <= 1'b0;
        state_r       <= FETCH;
        addr_err_r    <= addr_fault_s;
        if (exc_take_s) begin
          epc_r <= pc_r;
        end
      end else begin
        case (state_r)
          BOOT: begin
            state_r <= FETCH;
          end
          FETCH: begin
            if (accept_s) begin
              instr_r       <= imem_rdata;
              pc_r          <= fetch_pc_r;
              pc_plus4_r    <= fetch_pc_r + 32'd4;
              instr_valid_r <= 1'b1;
              fetch_pc_r    <= fetch_pc_r + 32'd4;
            end else if (instr_valid_r && stall) begin
              state_r <= HOLD;
            end else if (instr_valid_r) begin
              instr_valid_r <= 1'b0;
            end
          end
          HOLD: begin
            if (!stall) begin
              instr_valid_r <= 1'b0;
              state_r       <= FETCH;
            end
          end
          default: begin
            state_r       <= BOOT;
            instr_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign imem_req     = imem_req_s;
  assign imem_addr    = fetch_pc_r;
  assign instr_out    = instr_r;
  assign instr_valid  = instr_valid_r;
  assign pc_out       = pc_r;
  assign pc_plus4_out = pc_plus4_r;
  assign epc          = epc_r;
  assign addr_err     = addr_err_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenario tasks plus a delivery scoreboard.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, jr, exception, imem_ready;
  logic [31:0] branch_target, jr_target, imem_rdata;
  logic [25:0] jump_index;
  logic        imem_req, instr_valid, addr_err;
  logic [31:0] imem_addr, instr_out, pc_out, pc_plus4_out, epc;

  logic        w_rst, w_ready, w_req, w_valid, w_addr_err;
  logic [31:0] w_rdata, w_addr, w_instr, w_pc, w_pc4, w_epc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t       exp_q[$];
  item_t       last_exp;
  bit          pend;
  int          n_vec, n_err;
  logic [31:0] exp_pc;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index), .jr(jr),
    .jr_target(jr_target), .exception(exception), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .pc_out(pc_out),
    .pc_plus4_out(pc_plus4_out), .epc(epc), .addr_err(addr_err)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(w_rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index), .jr(jr),
    .jr_target(jr_target), .exception(exception), .imem_req(w_req),
    .imem_addr(w_addr), .imem_ready(w_ready), .imem_rdata(w_rdata),
    .instr_out(w_instr), .instr_valid(w_valid), .pc_out(w_pc),
    .pc_plus4_out(w_pc4), .epc(w_epc), .addr_err(w_addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic idle_inputs();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; exception = 1'b0;
    imem_ready = 1'b0; imem_rdata = 32'h0000_0000;
    branch_target = 32'h0000_0000; jr_target = 32'h0000_0000; jump_index = 26'h0;
  endtask

  task automatic push_exp(input logic [31:0] a);
    item_t it;
    it.pc = a;
    it.instr = mem_word(a);
    exp_q.push_back(it);
    pend = 1'b1;
  endtask

  // Scoreboard: pops on each expected delivery edge, otherwise checks the presented word is held.
  always @(posedge clk) begin
    if (pend) begin
      pend = 1'b0;
      #2;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: delivery expected but scoreboard empty");
      end else begin
        last_exp = exp_q.pop_front();
        if (instr_valid !== 1'b1 || pc_out !== last_exp.pc || instr_out !== last_exp.instr ||
            pc_plus4_out !== last_exp.pc + 32'd4) begin
          n_err++;
          $display("FAIL sb_deliver: got valid=%b pc=%h instr=%h pc4=%h, want valid=1 pc=%h instr=%h pc4=%h",
                   instr_valid, pc_out, instr_out, pc_plus4_out, last_exp.pc, last_exp.instr,
                   last_exp.pc + 32'd4);
        end
      end
    end else begin
      #2;
      if (instr_valid === 1'b1) begin
        n_vec++;
        if (pc_out !== last_exp.pc || instr_out !== last_exp.instr) begin
          n_err++;
          $display("FAIL sb_hold: got pc=%h instr=%h, want pc=%h instr=%h",
                   pc_out, instr_out, last_exp.pc, last_exp.instr);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({imem_req, instr_valid, addr_err} !== 3'b000) begin
      n_err++; $display("FAIL rst_flags: req/valid/err=%b want 000", {imem_req, instr_valid, addr_err});
    end
    n_vec++;
    if (imem_addr !== 32'h0 || instr_out !== 32'h0 || pc_out !== 32'h0 ||
        pc_plus4_out !== 32'h4 || epc !== 32'h0) begin
      n_err++; $display("FAIL rst_regs: addr=%h instr=%h pc=%h pc4=%h epc=%h want 0/0/0/4/0",
                        imem_addr, instr_out, pc_out, pc_plus4_out, epc);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL boot_req: req=%b want 0", imem_req);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL first_req: req=%b addr=%h valid=%b want 1/00000000/0",
                        imem_req, imem_addr, instr_valid);
    end
    exp_pc = 32'h0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1;
      imem_rdata = mem_word(exp_pc);
      #1;
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        n_err++; $display("FAIL seq_req: req=%b addr=%h want 1/%h", imem_req, imem_addr, exp_pc);
      end
      push_exp(exp_pc);
      exp_pc = exp_pc + 32'd4;
      @(negedge clk);
    end
    imem_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (instr_valid !== 1'b0) begin
      n_err++; $display("FAIL seq_drain: valid=%b want 0", instr_valid);
    end
  endtask

  task automatic branch_and_fetch(input logic [31:0] tgt);
    branch_taken = 1'b1;
    branch_target = tgt | 32'h0000_0003;
    #1;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL br_req: req=%b want 0", imem_req);
    end
    @(negedge clk);
    branch_taken = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = mem_word(tgt);
    #1;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== tgt) begin
      n_err++; $display("FAIL br_target: req=%b addr=%h want 1/%h", imem_req, imem_addr, tgt);
    end
    push_exp(tgt);
    @(negedge clk);
    imem_ready = 1'b0;
    exp_pc = tgt + 32'd4;
  endtask

  task automatic test_jump_priority();
    branch_and_fetch(32'h0040_0010);
    jump = 1'b1; branch_taken = 1'b1; jump_index = 26'h0000100;
    branch_target = 32'h0000_2000;
    imem_ready = 1'b1; imem_rdata = mem_word(32'h0040_0014);
    #1;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL jmp_req: req=%b want 0", imem_req);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_vec++;
    if (imem_addr !== 32'h0000_0400 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL jmp_target: addr=%h req=%b valid=%b want 00000400/1/0",
                        imem_addr, imem_req, instr_valid);
    end
    imem_ready = 1'b1; imem_rdata = mem_word(32'h0000_0400);
    push_exp(32'h0000_0400);
    @(negedge clk);
    imem_ready = 1'b0;
  endtask

  task automatic test_jr_addr_err();
    branch_and_fetch(32'h0000_0020);
    jr = 1'b1; jr_target = 32'h0000_1002;
    imem_ready = 1'b1; imem_rdata = mem_word(32'h0000_0024);
    @(negedge clk);
    idle_inputs();
    n_vec++;
    if (addr_err !== 1'b1 || epc !== 32'h20 || imem_addr !== 32'h80 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL jr_misalign: err=%b epc=%h addr=%h valid=%b want 1/00000020/00000080/0",
                        addr_err, epc, imem_addr, instr_valid);
    end
    @(negedge clk);
    n_vec++;
    if (addr_err !== 1'b0) begin
      n_err++; $display("FAIL jr_err_pulse: err=%b want 0", addr_err);
    end
    jr = 1'b1; jr_target = 32'h0000_3000;
    branch_taken = 1'b1; branch_target = 32'h0000_5000;
    @(negedge clk);
    idle_inputs();
    n_vec++;
    if (imem_addr !== 32'h3000 || addr_err !== 1'b0 || epc !== 32'h20) begin
      n_err++; $display("FAIL jr_aligned: addr=%h err=%b epc=%h want 00003000/0/00000020",
                        imem_addr, addr_err, epc);
    end
    exp_pc = 32'h3000;
  endtask

  task automatic test_stall();
    imem_ready = 1'b1; imem_rdata = mem_word(exp_pc);
    push_exp(exp_pc);
    @(negedge clk);
    stall = 1'b1;
    imem_rdata = mem_word(exp_pc + 32'd4);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_out !== mem_word(exp_pc)) begin
        n_err++; $display("FAIL stall_hold: req=%b valid=%b instr=%h want 0/1/%h",
                          imem_req, instr_valid, instr_out, mem_word(exp_pc));
      end
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL stall_bubble: req=%b want 0", imem_req);
    end
    @(negedge clk);
    exp_pc = exp_pc + 32'd4;
    #1;
    n_vec++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      n_err++; $display("FAIL stall_resume: valid=%b req=%b addr=%h want 0/1/%h",
                        instr_valid, imem_req, imem_addr, exp_pc);
    end
    push_exp(exp_pc);
    @(negedge clk);
    imem_ready = 1'b0;
  endtask

  task automatic test_exception();
    exception = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL exc_req: req=%b want 0", imem_req);
    end
    @(negedge clk);
    idle_inputs();
    n_vec++;
    if (imem_addr !== 32'h80 || instr_valid !== 1'b0 || epc !== exp_pc) begin
      n_err++; $display("FAIL exc_redirect: addr=%h valid=%b epc=%h want 00000080/0/%h",
                        imem_addr, instr_valid, epc, exp_pc);
    end
    imem_ready = 1'b1; imem_rdata = mem_word(32'h80);
    push_exp(32'h80);
    @(negedge clk);
    imem_ready = 1'b0;
    stall = 1'b1;
    @(negedge clk);
    exception = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    idle_inputs();
    n_vec++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h80 || epc !== 32'h80) begin
      n_err++; $display("FAIL exc_in_hold: valid=%b addr=%h epc=%h want 0/00000080/00000080",
                        instr_valid, imem_addr, epc);
    end
  endtask

  task automatic test_reset_mid();
    imem_ready = 1'b1; imem_rdata = mem_word(32'h80);
    push_exp(32'h80);
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL rst_in_hold: valid=%b req=%b addr=%h want 0/0/00000000",
                        instr_valid, imem_req, imem_addr);
    end
    rst = 1'b0;
    idle_inputs();
    #1;
    n_vec++;
    if (imem_req !== 1'b0 || pc_out !== 32'h0) begin
      n_err++; $display("FAIL rst_boot: req=%b pc=%h want 0/00000000", imem_req, pc_out);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (imem_req !== 1'b1) begin
      n_err++; $display("FAIL rst_refetch: req=%b want 1", imem_req);
    end
    rst = 1'b1;
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    w_rst = 1'b0;
    #1;
    n_vec++;
    if (w_req !== 1'b0 || w_addr !== 32'hFFFF_FFF8 || w_epc !== 32'h0) begin
      n_err++; $display("FAIL wrap_boot: req=%b addr=%h epc=%h want 0/fffffff8/00000000",
                        w_req, w_addr, w_epc);
    end
    @(negedge clk);
    a = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      w_ready = 1'b1; w_rdata = mem_word(a);
      #1;
      n_vec++;
      if (w_req !== 1'b1 || w_addr !== a) begin
        n_err++; $display("FAIL wrap_req: req=%b addr=%h want 1/%h", w_req, w_addr, a);
      end
      @(negedge clk);
      n_vec++;
      if (w_valid !== 1'b1 || w_pc !== a || w_instr !== mem_word(a) || w_pc4 !== a + 32'd4) begin
        n_err++; $display("FAIL wrap_deliver: valid=%b pc=%h instr=%h pc4=%h want 1/%h/%h/%h",
                          w_valid, w_pc, w_instr, w_pc4, a, mem_word(a), a + 32'd4);
      end
      a = a + 32'd4;
    end
    w_rdata = mem_word(a);
    w_rst = 1'b1;
    @(negedge clk);
    w_rst = 1'b0; w_ready = 1'b0;
    #1;
    n_vec++;
    if (w_valid !== 1'b0 || w_req !== 1'b0 || w_addr !== 32'hFFFF_FFF8) begin
      n_err++; $display("FAIL wrap_rst: valid=%b req=%b addr=%h want 0/0/fffffff8",
                        w_valid, w_req, w_addr);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (w_req !== 1'b1) begin
      n_err++; $display("FAIL wrap_refetch: req=%b want 1", w_req);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; pend = 1'b0;
    rst = 1'b1; w_rst = 1'b1; w_ready = 1'b0; w_rdata = 32'h0;
    exp_pc = 32'h0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_jump_priority();
    test_jr_addr_err();
    test_stall();
    test_exception();
    test_reset_mid();
    test_wrap();
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_leftover: %0d entries undelivered, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
